// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eq_pkg
// Purpose  : Shared widths, filter dimensions and the I2S receiver state
//            encoding for the audio front end and the downstream filter.
// Contents : SAMPLE_W, COEF_W, RESULT_W, ORDER, rx_state_t
// Revision : 1.0 - initial release
// ============================================================================
package eq_pkg;

  localparam int SAMPLE_W = 24;
  localparam int COEF_W   = 16;
  localparam int RESULT_W = 44;
  localparam int ORDER    = 12;

  // Receiver sequencing: wait for our slot, drop the I2S delay bit,
  // shift the word, then coast through slot padding.
  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_DELAY   = 2'd1,
    RX_SHIFT   = 2'd2,
    RX_WAIT_LR = 2'd3
  } rx_state_t;

endpackage : eq_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer bringing one asynchronous bit into the
//            clk domain. Both flops reset to 0.
// Ports    : clk   - destination clock
//            rst_n - asynchronous active-low reset
//            d     - asynchronous input bit
//            q     - synchronized output (2 clk cycles of latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/i2s_sample_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_rx
// Purpose  : Captures one channel of an I2S stream (MSB first, one-bit
//            delay after the word-select edge) and hands each complete word
//            to the downstream filter as a sample plus a one-cycle start.
// Ports    : i_clk          - system clock (>= 4x bit clock)
//            i_rst_n        - asynchronous active-low reset
//            i_bclk         - I2S bit clock (asynchronous)
//            i_lrclk        - I2S word select (asynchronous)
//            i_sdata        - I2S serial data (asynchronous)
//            i_filter_ready - filter can accept a new start
//            i_clear        - clears the sticky status flags
//            o_sample       - last accepted word
//            o_start        - one-cycle pulse when o_sample is loaded
//            o_overrun      - sticky: word dropped, filter busy
//            o_frame_err    - sticky: slot ended before a full word
// Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_rx #(
  parameter int SAMPLE_W = eq_pkg::SAMPLE_W,
  parameter int CHANNEL  = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_bclk,
  input  logic                i_lrclk,
  input  logic                i_sdata,
  input  logic                i_filter_ready,
  input  logic                i_clear,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_start,
  output logic                o_overrun,
  output logic                o_frame_err
);

  import eq_pkg::*;

  localparam int                c_cnt_w    = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(SAMPLE_W - 1);
  localparam logic               c_chan_lvl = (CHANNEL != 0);

  // --------------------------------------------------------------------------
  // Synchronizers plus one history stage each, so bclk, lrclk and sdata all
  // arrive with the same latency and edges can be found by comparison.
  // --------------------------------------------------------------------------
  logic w_bclk_s;
  logic w_lrclk_s;
  logic w_sdata_s;

  sync_2ff u_sync_bclk  (.clk(i_clk), .rst_n(i_rst_n), .d(i_bclk),  .q(w_bclk_s));
  sync_2ff u_sync_lrclk (.clk(i_clk), .rst_n(i_rst_n), .d(i_lrclk), .q(w_lrclk_s));
  sync_2ff u_sync_sdata (.clk(i_clk), .rst_n(i_rst_n), .d(i_sdata), .q(w_sdata_s));

  logic       r_bclk_h;
  logic       r_lrclk_h;
  logic       r_sdata_h;
  logic [1:0] r_fill;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bclk_h  <= 1'b0;
      r_lrclk_h <= 1'b0;
      r_sdata_h <= 1'b0;
      r_fill    <= 2'd0;
    end else begin
      r_bclk_h  <= w_bclk_s;
      r_lrclk_h <= w_lrclk_s;
      r_sdata_h <= w_sdata_s;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  // The first three cycles after reset only see the pipeline filling with
  // the current lrclk level; an apparent edge there is not a real frame
  // boundary, so word-select edges are masked until the pipe is primed.
  logic w_armed;
  logic w_lr_edge;
  logic w_bclk_rise;
  logic w_sel;

  assign w_armed     = (r_fill == 2'd3);
  assign w_lr_edge   = w_armed & (w_lrclk_s ^ r_lrclk_h);
  assign w_bclk_rise = w_bclk_s & ~r_bclk_h;
  assign w_sel       = (w_lrclk_s == c_chan_lvl);

  // --------------------------------------------------------------------------
  // Capture FSM with registered outputs.
  // Data is taken from the history stage: at a detected rise it holds the
  // value from the preceding cycle, still inside the stable low half of
  // bclk given the 4x clock ratio.
  // --------------------------------------------------------------------------
  rx_state_t           r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_start;
  logic                r_overrun;
  logic                r_frame_err;
  logic [SAMPLE_W-1:0] w_word;

  assign w_word = {r_shift[SAMPLE_W-2:0], r_sdata_h};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_sample    <= '0;
      r_start     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_start <= 1'b0;

      // Clear first so a coincident set event below takes precedence.
      if (i_clear) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end

      case (r_state)
        RX_IDLE: begin
          if (w_lr_edge && w_sel) begin
            r_state <= RX_DELAY;
          end
        end

        RX_DELAY: begin
          if (w_lr_edge) begin
            // Slot cut short: flag it and treat the edge as IDLE would.
            r_frame_err <= 1'b1;
            r_cnt       <= '0;
            r_state     <= w_sel ? RX_DELAY : RX_IDLE;
          end else if (w_bclk_rise) begin
            r_cnt   <= '0;
            r_state <= RX_SHIFT;
          end
        end

        RX_SHIFT: begin
          if (w_lr_edge) begin
            r_frame_err <= 1'b1;
            r_cnt       <= '0;
            r_state     <= w_sel ? RX_DELAY : RX_IDLE;
          end else if (w_bclk_rise) begin
            r_shift <= w_word;
            if (r_cnt == c_last) begin
              r_cnt   <= '0;
              r_state <= RX_WAIT_LR;
              if (i_filter_ready) begin
                r_sample <= w_word;
                r_start  <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        RX_WAIT_LR: begin
          if (w_lr_edge) begin
            r_state <= RX_IDLE;
          end
        end

        default: begin
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign o_sample    = r_sample;
  assign o_start     = r_start;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;

endmodule : i2s_sample_rx
`default_nettype wire

// File: doc/i2s_sample_rx.md
I2S_SAMPLE_RX -- requirements
Module: i2s_sample_rx

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24, meaning the audio word width delivered to the filter.
REQ-002 SHALL have parameter CHANNEL, default 0, meaning the captured slot: 0 = left (i_lrclk low), 1 = right (i_lrclk high).
REQ-003 SHALL have port i_clk, input, 1, the single system clock.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_bclk, input, 1, I2S bit clock, asynchronous to i_clk.
REQ-006 SHALL have port i_lrclk, input, 1, I2S word select, asynchronous to i_clk.
REQ-007 SHALL have port i_sdata, input, 1, I2S serial data, MSB first.
REQ-008 SHALL have port i_filter_ready, input, 1, high when the downstream filter accepts a new start.
REQ-009 SHALL have port i_clear, input, 1, synchronous clear of the sticky status flags.
REQ-010 SHALL have port o_sample, output, SAMPLE_W, last accepted word; drives the filter's i_sample.
REQ-011 SHALL have port o_start, output, 1, single-cycle pulse; drives the filter's i_start.
REQ-012 SHALL have port o_overrun, output, 1, sticky: a word was dropped because the filter was busy.
REQ-013 SHALL have port o_frame_err, output, 1, sticky: a slot ended before SAMPLE_W bits were received.

Function
REQ-014 SHALL pass i_bclk, i_lrclk and i_sdata each through a 2-flop synchronizer, then one further history register, so that all three share identical latency.
REQ-015 SHALL detect a bclk rise in a cycle where synchronized bclk = 1 and its history = 0, and an lrclk edge in a cycle where synchronized lrclk differs from its history.
REQ-016 SHALL require an i_clk frequency of at least 4x the i_bclk frequency; behaviour below that ratio is undefined.
REQ-017 SHALL implement FSM states IDLE, DELAY, SHIFT and WAIT_LR.
- IDLE -> DELAY on an lrclk edge whose new level selects CHANNEL; all other edges are ignored.
- DELAY -> SHIFT on the next bclk rise; the I2S one-bit delay is discarded.
- SHIFT: shift synchronized sdata into a SAMPLE_W register, MSB first, on each bclk rise; after SAMPLE_W bits, go to WAIT_LR.
- WAIT_LR: ignore further bclk rises (slot padding, e.g. 32-bit slots); go to IDLE on an lrclk edge.
REQ-018 SHALL treat an lrclk edge seen in DELAY or SHIFT as a frame error: set o_frame_err, discard the partial word, and re-evaluate that edge exactly as IDLE would in the same cycle.
REQ-019 SHALL, in the cycle after the SAMPLE_W-th bit is captured, load o_sample and pulse o_start high for exactly one cycle, provided i_filter_ready was high in the capture cycle.
REQ-020 SHALL, if i_filter_ready was low in the capture cycle, leave o_sample unchanged, not pulse o_start, and set o_overrun.
REQ-021 SHALL hold o_sample stable between o_start pulses.
REQ-022 SHALL treat o_sample as raw two's-complement audio bits; no sign extension, rounding or scaling is applied.
REQ-023 SHALL clear both sticky flags on i_clear; if a set event coincides with i_clear, the set wins.
REQ-024 SHALL produce at most one o_start per lrclk period.

Reset
REQ-025 SHALL, on i_rst_n low, asynchronously force state IDLE, bit counter 0, all synchronizer and history flops 0, o_sample 0, o_start 0, o_overrun 0 and o_frame_err 0.
REQ-026 SHALL, after reset release, ignore any lrclk edge produced purely by synchronizer fill (history 0 -> 1 within the first 3 cycles), and start capturing only at the first genuine edge.
REQ-027 SHALL abandon any word in progress when reset is asserted mid-frame, with no o_start pulse afterwards for that word.

Structure
REQ-028 SHALL take SAMPLE_W default, COEF_W = 16, RESULT_W = 44, ORDER = 12 and the rx state enum from shared package eq_pkg.
REQ-029 SHALL instantiate a sub-module sync_2ff, once per asynchronous input.

Verification
REQ-030 SHALL cover a left slot of 24'hA5A5A5 in 32-bit slots with bclk = i_clk/8 and filter ready -> o_sample = 24'hA5A5A5, one o_start pulse, no flags set.
REQ-031 SHALL cover the extremes 24'hFFFFFF then 24'h000000 on consecutive left slots -> two o_start pulses, one lrclk period apart, carrying those values in order.
REQ-032 SHALL cover i_filter_ready held low during a slot of 24'h123456 -> no o_start, o_sample keeps its prior value, o_overrun = 1 until i_clear.
REQ-033 SHALL cover lrclk toggling after only 10 bits -> o_frame_err = 1, no o_start, and the next full slot of 24'h00F00F is delivered correctly.
REQ-034 SHALL cover CHANNEL = 1 with left = 24'h111111 and right = 24'h222222 -> only 24'h222222 appears on o_sample.
REQ-035 SHALL cover reset asserted at bit 12 of a slot, then a clean slot of 24'h7FFFFF -> all outputs 0 during reset, then exactly one o_start with 24'h7FFFFF.
